// File: rtl/tile_fetch_unit.sv
// tile_fetch_unit
//   Paces the tiled-matmul address generator with credits, issues memory reads
//   for A/B operand addresses, and returns the read data in accept order,
//   tagged with its operand class, through a first-word-fall-through FIFO.
//   C addresses bypass memory and go straight to the writeback path.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   enable            allow new read_req issue
//   read_req          request one address from the generator (registered)
//   agu_addr/id/valid generator address stream, accepted unconditionally
//   mem_rd_en/addr    memory read strobe and address (combinational)
//   mem_rd_valid/data in-order, non-stallable memory return
//   out_data/id/valid/ready  tagged operand stream to the PE array
//   c_addr/c_addr_valid      registered C address pulse for writeback
//   err_id            sticky flag for a reserved (id 3) address
//   busy              credits outstanding or a C pulse pending
module tile_fetch_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  output logic                  read_req,
  input  logic [ADDR_WIDTH-1:0] agu_addr,
  input  logic [1:0]            agu_id,
  input  logic                  agu_valid,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_rd_valid,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_id,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] c_addr,
  output logic                  c_addr_valid,
  output logic                  err_id,
  output logic                  busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [CW-1:0]   credits;
  logic [CW-1:0]   credits_next;

  logic            tag_mem [DEPTH];
  logic [PW-1:0]   tag_wr;
  logic [PW-1:0]   tag_rd;
  logic [CW-1:0]   tag_cnt;

  logic [DATA_WIDTH:0] dat_mem [DEPTH];
  logic [PW-1:0]   dat_wr;
  logic [PW-1:0]   dat_rd;
  logic [CW-1:0]   dat_cnt;

  logic            ab_acc;
  logic            rel;
  logic            is_c;
  logic            tag_pop;
  logic            dat_pop;

  assign ab_acc  = agu_valid && !agu_id[1];
  // C and reserved addresses both hand their credit straight back
  assign rel     = agu_valid && agu_id[1];
  assign is_c    = agu_valid && (agu_id == 2'd2);
  // A return with no tag outstanding (e.g. traffic from before a reset) is dropped
  assign tag_pop = mem_rd_valid && (tag_cnt != '0);
  assign dat_pop = out_valid && out_ready;

  assign mem_rd_en = ab_acc;
  assign mem_addr  = ab_acc ? agu_addr : '0;

  assign out_valid = (dat_cnt != '0);
  assign out_data  = out_valid ? dat_mem[dat_rd][DATA_WIDTH-1:0] : '0;
  assign out_id    = out_valid && dat_mem[dat_rd][DATA_WIDTH];

  assign busy = (credits != FULL) || c_addr_valid;

  // Each read_req reserves a slot in both FIFOs; the slot is handed back when
  // the word leaves the output or the address turns out not to need memory.
  assign credits_next = credits + CW'(dat_pop) + CW'(rel) - CW'(read_req);

  always_ff @(posedge clk) begin
    if (rst) begin
      credits      <= FULL;
      read_req     <= 1'b0;
      tag_wr       <= '0;
      tag_rd       <= '0;
      tag_cnt      <= '0;
      dat_wr       <= '0;
      dat_rd       <= '0;
      dat_cnt      <= '0;
      c_addr       <= '0;
      c_addr_valid <= 1'b0;
      err_id       <= 1'b0;
    end else begin
      credits  <= credits_next;
      read_req <= enable && (credits_next != '0);

      if (ab_acc)  tag_wr <= tag_wr + PW'(1);
      if (tag_pop) tag_rd <= tag_rd + PW'(1);
      tag_cnt <= tag_cnt + CW'(ab_acc) - CW'(tag_pop);

      if (tag_pop) dat_wr <= dat_wr + PW'(1);
      if (dat_pop) dat_rd <= dat_rd + PW'(1);
      dat_cnt <= dat_cnt + CW'(tag_pop) - CW'(dat_pop);

      c_addr_valid <= is_c;
      if (is_c) c_addr <= agu_addr;

      if (agu_valid && (agu_id == 2'd3)) err_id <= 1'b1;
    end
  end

  // Storage arrays need no reset; occupancy counters define what is valid.
  always_ff @(posedge clk) begin
    if (ab_acc)  tag_mem[tag_wr] <= agu_id[0];
    if (tag_pop) dat_mem[dat_wr] <= {tag_mem[tag_rd], mem_rd_data};
  end

endmodule

// File: tb/tb_tile_fetch_unit.sv
module tb_tile_fetch_unit;

  localparam int DEPTH = 8;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        read_req;
  logic [31:0] agu_addr;
  logic [1:0]  agu_id;
  logic        agu_valid;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic        mem_rd_valid;
  logic [31:0] mem_rd_data;
  logic [31:0] out_data;
  logic        out_id;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] c_addr;
  logic        c_addr_valid;
  logic        err_id;
  logic        busy;

  tile_fetch_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .enable(enable), .read_req(read_req),
    .agu_addr(agu_addr), .agu_id(agu_id), .agu_valid(agu_valid),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .out_data(out_data), .out_id(out_id), .out_valid(out_valid), .out_ready(out_ready),
    .c_addr(c_addr), .c_addr_valid(c_addr_valid), .err_id(err_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int due; logic [31:0] data; } mem_t;
  typedef struct { logic id; logic [31:0] data; } exp_t;
  typedef struct { logic [31:0] addr; logic [1:0] id; } gen_t;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // stimulus controls, written by the main sequence
  logic en_drv = 1'b0;
  logic rdy_val = 1'b0;
  logic rdy_rand = 1'b0;
  int   lat_lo = 1;
  int   lat_hi = 1;
  int   gen_mode = 0;
  gen_t gen_q[$];
  logic [31:0] force_q[$];

  // reference model
  mem_t mem_q[$];
  exp_t exp_q[$];
  int   cred = DEPTH;
  int   n_ret = 0;
  int   n_pop = 0;
  int   last_due = 0;
  logic err_m = 1'b0;
  logic c_exp_v = 1'b0;
  logic [31:0] c_exp_a = '0;
  logic en_prev = 1'b0;

  // observation logs for directed tests
  int   n_reads = 0;
  int   n_acc = 0;
  int   n_hs = 0;
  int   acc_cyc = 0;
  logic [31:0] acc_addr = '0;
  logic acc_en = 1'b0;
  int   first_hs = -2;
  int   first_rr = -2;
  exp_t out_log[$];
  int   c_cnt = 0;
  logic [31:0] c_last = '0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Generator, memory, consumer and cycle-by-cycle compare against the model.
  initial begin
    enable = 0; agu_valid = 0; agu_addr = '0; agu_id = '0;
    mem_rd_valid = 0; mem_rd_data = '0; out_ready = 0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (rst) begin
        mem_q.delete(); exp_q.delete();
        cred = DEPTH; n_ret = 0; n_pop = 0; last_due = 0;
        err_m = 0; c_exp_v = 0; en_prev = 0;
      end else begin
        chk("read_req", read_req, en_prev && (cred > 0));
        chk("out_valid", out_valid, (n_ret - n_pop) > 0);
        if (out_valid && exp_q.size() > 0)
          chk("out_word", {31'd0, out_id, out_data}, {31'd0, exp_q[0].id, exp_q[0].data});
        chk("c_addr_valid", c_addr_valid, c_exp_v);
        if (c_exp_v) chk("c_addr", c_addr, c_exp_a);
        chk("err_id", err_id, err_m);
        chk("busy", busy, (cred != DEPTH) || c_exp_v);
        if (read_req && first_hs >= 0 && first_rr == -1) first_rr = cyc;
      end

      if (rst) begin
        enable = 0; agu_valid = 0; agu_addr = '0; agu_id = '0;
        mem_rd_valid = 0; mem_rd_data = '0; out_ready = 0;
      end else begin
        gen_t g;
        enable = en_drv;
        out_ready = rdy_rand ? 1'($urandom_range(1, 0)) : rdy_val;
        if (read_req) begin
          if (gen_q.size() > 0) g = gen_q.pop_front();
          else begin
            g.addr = $urandom & 32'hFFFF_FFFC;
            g.id = (gen_mode == 1) ? 2'd1 : (gen_mode == 2) ? 2'd0 : 2'($urandom_range(2, 0));
          end
          agu_valid = 1; agu_addr = g.addr; agu_id = g.id;
        end else begin
          agu_valid = 0; agu_addr = '0; agu_id = '0;
        end
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
          assert (n_ret < exp_q.size() + n_pop);
          mem_rd_valid = 1; mem_rd_data = mem_q[0].data; mem_q.delete(0);
        end else begin
          mem_rd_valid = 0; mem_rd_data = '0;
        end
      end

      #1;
      if (!rst) begin
        logic ab;
        ab = agu_valid && (agu_id < 2);
        chk("mem_rd_en", mem_rd_en, ab);
        if (ab) chk("mem_addr", mem_addr, agu_addr);
        if (out_valid && out_ready) begin
          out_log.push_back('{out_id, out_data});
          if (exp_q.size() > 0) exp_q.delete(0);
          n_pop++; n_hs++; cred++;
          if (first_hs == -1) first_hs = cyc;
        end
        if (c_addr_valid) begin c_cnt++; c_last = c_addr; end
        if (read_req) cred--;
        if (agu_valid) n_acc++;
        if (agu_valid && agu_id[1]) cred++;
        if (agu_valid && agu_id == 2'd3) err_m = 1;
        c_exp_v = agu_valid && (agu_id == 2'd2);
        c_exp_a = agu_addr;
        if (ab) begin
          int d;
          logic [31:0] dat;
          dat = (force_q.size() > 0) ? force_q.pop_front() : $urandom;
          d = cyc + int'($urandom_range(lat_hi, lat_lo));
          if (d <= last_due) d = last_due + 1;
          last_due = d;
          mem_q.push_back('{d, dat});
          exp_q.push_back('{agu_id[0], dat});
          n_reads++; acc_cyc = cyc; acc_addr = mem_addr; acc_en = mem_rd_en;
        end
        if (mem_rd_valid) n_ret++;
        en_prev = enable;
        chk("credit_range", (cred >= 0) && (cred <= DEPTH), 1);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_read_req"}, read_req, 0);
    chk({tag, "_mem_rd_en"}, mem_rd_en, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_id"}, out_id, 0);
    chk({tag, "_c_addr"}, c_addr, 0);
    chk({tag, "_c_addr_valid"}, c_addr_valid, 0);
    chk({tag, "_err_id"}, err_id, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy && !out_valid) break;
    end
    chk({tag, "_idle"}, {busy, out_valid}, 0);
  endtask

  initial begin
    rst = 1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 0;

    // single A read, latency 3
    gen_q.push_back('{32'h100, 2'd0});
    force_q.push_back(32'hDEAD);
    lat_lo = 3; lat_hi = 3; rdy_val = 0; n_reads = 0;
    en_drv = 1; @(negedge clk); en_drv = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk("t1_out_valid", out_valid, 1);
    chk("t1_latency", cyc - acc_cyc, 4);
    chk("t1_mem_addr", acc_addr, 32'h100);
    chk("t1_mem_rd_en", acc_en, 1);
    chk("t1_out_data", out_data, 32'hDEAD);
    chk("t1_out_id", out_id, 0);
    chk("t1_reads", n_reads, 1);
    rdy_val = 1;
    wait_idle("t1", 20);

    // credit exhaustion with the consumer stalled
    n_reads = 0; gen_mode = 1; rdy_val = 0; lat_lo = 2; lat_hi = 2;
    en_drv = 1;
    repeat (20) @(negedge clk);
    chk("t2_reads", n_reads, 8);
    chk("t2_read_req_stalled", read_req, 0);
    chk("t2_out_valid", out_valid, 1);
    first_hs = -1; first_rr = -1; rdy_val = 1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (first_rr >= 0) break;
    end
    chk("t2_resume", first_rr - first_hs, 1);
    en_drv = 0; first_hs = -2;
    wait_idle("t2", 100);

    // interleaved A, B, C, A
    gen_q.push_back('{32'h0, 2'd0});
    gen_q.push_back('{32'h40, 2'd1});
    gen_q.push_back('{32'h800, 2'd2});
    gen_q.push_back('{32'h4, 2'd0});
    force_q.push_back(32'h11); force_q.push_back(32'h22); force_q.push_back(32'h33);
    gen_mode = 0; lat_lo = 1; lat_hi = 1; rdy_val = 1;
    out_log.delete(); c_cnt = 0;
    en_drv = 1; repeat (4) @(negedge clk); en_drv = 0;
    wait_idle("t3", 50);
    chk("t3_c_count", c_cnt, 1);
    chk("t3_c_addr", c_last, 32'h800);
    chk("t3_out_count", out_log.size(), 3);
    if (out_log.size() == 3) begin
      chk("t3_id0", out_log[0].id, 0); chk("t3_data0", out_log[0].data, 32'h11);
      chk("t3_id1", out_log[1].id, 1); chk("t3_data1", out_log[1].data, 32'h22);
      chk("t3_id2", out_log[2].id, 0); chk("t3_data2", out_log[2].data, 32'h33);
    end

    // randomised traffic
    n_acc = 0; n_reads = 0; n_hs = 0;
    gen_mode = 0; lat_lo = 1; lat_hi = 6; rdy_rand = 1;
    for (int i = 0; i < 4000 && n_acc < 200; i++) begin
      @(negedge clk);
      en_drv = ($urandom_range(3, 0) != 0);
    end
    en_drv = 0;
    wait_idle("t4", 400);
    rdy_rand = 0;
    chk("t4_accepted", n_acc >= 200, 1);
    chk("t4_all_returned", n_hs, n_reads);

    // reserved id, then reset mid-burst
    n_reads = 0;
    gen_q.push_back('{32'h123, 2'd3});
    en_drv = 1; @(negedge clk); en_drv = 0;
    repeat (5) @(negedge clk);
    chk("t5_no_read", n_reads, 0);
    chk("t5_err_id", err_id, 1);
    chk("t5_busy", busy, 0);
    rdy_val = 0; lat_lo = 6; lat_hi = 6; gen_mode = 2; n_reads = 0;
    en_drv = 1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (n_reads >= 5) break;
    end
    chk("t5_outstanding", n_reads, 5);
    chk("t5_err_held", err_id, 1);
    en_drv = 0; rst = 1;
    @(negedge clk);
    check_all_zero("t5_rst");
    rst = 0;
    repeat (12) @(negedge clk);
    chk("t5_after_busy", busy, 0);
    chk("t5_after_out_valid", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tile_fetch_unit.md
Name: tile_fetch_unit

Overview:
- Sits directly downstream of the tiled-matmul address generator.
- Paces the generator through its `read_req` input and accepts the generated address stream (`addr`, `addr_id`, `valid`).
- Issues memory reads for A/B operand addresses and returns the read data in order, tagged, to the PE-array operand buffers.
- Forwards C (result) addresses to the writeback path without reading memory.
- Uses credit-based flow control, so the non-stallable memory return never overflows the internal buffer.

Parameters:
- ADDR_WIDTH, 32, address width; matches the generator.
- DATA_WIDTH, 32, memory read-data width.
- DEPTH, 8, entries in the tag FIFO and in the data FIFO. Also the maximum number of credits. Must be a power of two, ≥ 2.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  when 0, no new `read_req` is issued; in-flight traffic drains normally.
- read_req  out  1  request one address from the generator.
- agu_addr  in  ADDR_WIDTH  generator address.
- agu_id  in  2  address class: 0 = A, 1 = B, 2 = C, 3 = reserved.
- agu_valid  in  1  `agu_addr`/`agu_id` valid this cycle; accepted unconditionally.
- mem_rd_en  out  1  memory read strobe.
- mem_addr  out  ADDR_WIDTH  memory read address.
- mem_rd_valid  in  1  read data valid; in-order, variable latency ≥ 1, cannot be stalled.
- mem_rd_data  in  DATA_WIDTH  read data.
- out_data  out  DATA_WIDTH  operand word.
- out_id  out  1  0 = A, 1 = B.
- out_valid  out  1  `out_data`/`out_id` valid.
- out_ready  in  1  consumer accepts when `out_valid && out_ready`.
- c_addr  out  ADDR_WIDTH  C address for writeback.
- c_addr_valid  out  1  one-cycle pulse per C address.
- err_id  out  1  sticky: `agu_id` = 3 was received.
- busy  out  1  credits outstanding ≠ 0 or an output is pending.

Behaviour:
- Reset (rst = 1 at a clock edge), regardless of in-flight traffic:
  - All outputs go to 0. Credits reset to DEPTH. Both FIFOs are emptied.
  - Memory data returning after reset is ignored; the system resets memory and generator together.
- Credit counter (width clog2(DEPTH)+1):
  - Decrements by 1 on each cycle with `read_req` = 1.
  - Increments by 1 on each `out` handshake, each C pass-through, and each id-3 drop.
  - Simultaneous decrement and increment leaves it unchanged.
  - Never exceeds DEPTH and never goes below 0.
- `read_req` is registered: `read_req` = enable && credits_next > 0, where credits_next already accounts for the current cycle's decrement. At most one `read_req` per cycle; back-to-back requests are allowed while credits last.
- Address accept (`agu_valid` = 1):
  - id 0/1:
    - Same cycle: `mem_rd_en` = 1, `mem_addr` = `agu_addr` (combinational pass-through).
    - id[0] is pushed into the tag FIFO.
  - id 2:
    - Next cycle: `c_addr_valid` = 1 and `c_addr` = `agu_addr` (registered).
    - Credit released.
  - id 3: no memory access; credit released; `err_id` set to 1 until reset.
- Memory return (`mem_rd_valid` = 1):
  - Pushes {tag FIFO head, `mem_rd_data`} into the data FIFO and pops the tag FIFO.
  - Credits guarantee the data FIFO has space. `mem_rd_valid` with an empty tag FIFO is a protocol error; the bench asserts it never occurs.
- Output path:
  - `out_valid` = data FIFO not empty (first-word-fall-through).
  - `out_data`/`out_id` = head of the data FIFO, held stable while `out_valid && !out_ready`.
  - Pop on handshake.
  - Push and pop in the same cycle are allowed, including on a full FIFO when pop and push coincide.
- Ordering: output order equals the accept order of the A/B addresses. C addresses are independent of that order.
- FIFO pointers are clog2(DEPTH) bits and wrap modulo DEPTH. Full and empty are distinguished by occupancy counters.
- Latency:
  - `agu_valid` to `mem_rd_en`: 0 cycles.
  - `mem_rd_valid` to `out_valid`: 1 cycle.
- `busy` = (credits ≠ DEPTH) || `c_addr_valid`.

Test Plan:
- Reset then enable = 1, single id-0 address 0x100, memory latency 3 returning 0xDEAD → `mem_rd_en` with `mem_addr` = 0x100 in the accept cycle; `out_valid` with `out_data` = 0xDEAD, `out_id` = 0 four cycles after accept; credits back to 8 after the handshake.
- `out_ready` held 0, generator responds to every `read_req` with id 1 → exactly 8 reads issued; `read_req` = 0 thereafter; data FIFO holds 8 entries; asserting `out_ready` drains in order and `read_req` resumes the cycle after the first pop.
- Interleaved ids 0, 1, 2, 0 (addresses 0x0, 0x40, 0x800, 0x4), latency 1 → `c_addr_valid` pulse with `c_addr` = 0x800; outputs in order ids 0, 1, 0 with the matching data.
- Randomised memory latency 1–6, `out_ready` toggling, 200 addresses → scoreboard matches every word and id, no overflow, credits return to 8.
- `agu_id` = 3 → no `mem_rd_en`, `err_id` = 1 and stays set; rst = 1 mid-burst with 5 reads outstanding → the next cycle all outputs are 0, credits = 8, `err_id` = 0.
